// File: rtl/pe_pkg.sv
// Shared constants and types for the PE operand feeder.
package pe_pkg;

  localparam int DFLT_DATA_W = 512;
  localparam int DFLT_ADDR_W = 16;
  localparam int DFLT_LEN_W  = 8;

  // Bit positions inside the 2-bit PE control tag.
  localparam int CTL_FIRST = 0;
  localparam int CTL_LAST  = 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/pe_feeder_tagpipe.sv
// Valid/first/last tag delay line whose depth matches the operand SRAM read latency.
module pe_feeder_tagpipe #(
  parameter int RD_LAT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       vld_i,
  input  logic [1:0] ctl_i,
  output logic       vld_o,
  output logic [1:0] ctl_o,
  output logic       any_vld_o
);

  logic [RD_LAT-1:0]      vld_q;
  logic [RD_LAT-1:0][1:0] ctl_q;

  // Shift tags one stage per cycle; reset drops every row in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= {RD_LAT{1'b0}};
      ctl_q <= {(2*RD_LAT){1'b0}};
    end else begin
      vld_q[0] <= vld_i;
      ctl_q[0] <= ctl_i;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        ctl_q[i] <= ctl_q[i-1];
      end
    end
  end

  assign vld_o     = vld_q[RD_LAT-1];
  assign ctl_o     = ctl_q[RD_LAT-1];
  assign any_vld_o = |vld_q;

endmodule

// File: rtl/pe_feeder.sv
// Streams neuron/weight SRAM rows into parallel_pe for each dot-product instruction.
// Define PE_FEEDER_PERF_EN to build the saturating row/instruction performance counters.
module pe_feeder
  import pe_pkg::*;
#(
  parameter int DATA_W = DFLT_DATA_W,
  parameter int ADDR_W = DFLT_ADDR_W,
  parameter int LEN_W  = DFLT_LEN_W,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inst_vld,
  output logic              inst_rdy,
  input  logic [LEN_W-1:0]  inst_len,
  input  logic [ADDR_W-1:0] inst_nbase,
  input  logic [ADDR_W-1:0] inst_wbase,
  output logic              nram_rd_en,
  output logic [ADDR_W-1:0] nram_addr,
  input  logic [DATA_W-1:0] nram_rdata,
  output logic              wram_rd_en,
  output logic [ADDR_W-1:0] wram_addr,
  input  logic [DATA_W-1:0] wram_rdata,
  output logic [DATA_W-1:0] pe_neuron,
  output logic [DATA_W-1:0] pe_weight,
  output logic [1:0]        pe_ctl,
  output logic              pe_vld,
  output logic              busy,
  output logic              err_zero_len,
  output logic [31:0]       perf_row_cnt,
  output logic [31:0]       perf_inst_cnt
);

  localparam logic [LEN_W-1:0]  LEN_ZERO = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0]  LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  iter_q, iter_d, len_q, len_d;
  logic [ADDR_W-1:0] naddr_q, naddr_d, waddr_q, waddr_d;
  logic              rdy_q, rdy_d, zero_err_q, zero_err_d;
  logic              hs_s, last_s, pipe_vld_s, pipe_any_s;
  logic [1:0]        ctl_s, pipe_ctl_s;

  assign hs_s   = inst_vld && rdy_q;
  assign last_s = (state_q == RUN) && (iter_q == (len_q - LEN_ONE));

  // Next-state logic; a handshake on the final row reloads directly so issue never bubbles.
  always_comb begin
    state_d    = state_q;
    iter_d     = iter_q;
    len_d      = len_q;
    naddr_d    = naddr_q;
    waddr_d    = waddr_q;
    zero_err_d = hs_s && (inst_len == LEN_ZERO);
    if (hs_s && (inst_len != LEN_ZERO)) begin
      state_d = RUN;
      iter_d  = LEN_ZERO;
      len_d   = inst_len;
      naddr_d = inst_nbase;
      waddr_d = inst_wbase;
    end else if (state_q == RUN) begin
      if (last_s) begin
        state_d = IDLE;
        iter_d  = LEN_ZERO;
      end else begin
        iter_d  = iter_q + LEN_ONE;
        naddr_d = naddr_q + ADDR_ONE;
        waddr_d = waddr_q + ADDR_ONE;
      end
    end else begin
      state_d = IDLE;
    end
    rdy_d = (state_d == IDLE) || (iter_d == (len_d - LEN_ONE));
  end

  // Instruction and address state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      iter_q     <= LEN_ZERO;
      len_q      <= LEN_ZERO;
      naddr_q    <= {ADDR_W{1'b0}};
      waddr_q    <= {ADDR_W{1'b0}};
      rdy_q      <= 1'b1;
      zero_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      iter_q     <= iter_d;
      len_q      <= len_d;
      naddr_q    <= naddr_d;
      waddr_q    <= waddr_d;
      rdy_q      <= rdy_d;
      zero_err_q <= zero_err_d;
    end
  end

  assign ctl_s[CTL_FIRST] = (iter_q == LEN_ZERO);
  assign ctl_s[CTL_LAST]  = last_s;

  pe_feeder_tagpipe #(
    .RD_LAT (RD_LAT)
  ) u_tagpipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .vld_i     (state_q == RUN),
    .ctl_i     (ctl_s),
    .vld_o     (pipe_vld_s),
    .ctl_o     (pipe_ctl_s),
    .any_vld_o (pipe_any_s)
  );

  assign inst_rdy     = rdy_q;
  assign nram_rd_en   = (state_q == RUN);
  assign wram_rd_en   = (state_q == RUN);
  assign nram_addr    = naddr_q;
  assign wram_addr    = waddr_q;
  assign err_zero_len = zero_err_q;
  assign busy         = (state_q != IDLE) || pipe_any_s;

  // SRAM data is only meaningful on rows the tag pipe marks valid.
  assign pe_vld    = pipe_vld_s;
  assign pe_ctl    = pipe_vld_s ? pipe_ctl_s : 2'b00;
  assign pe_neuron = pipe_vld_s ? nram_rdata : {DATA_W{1'b0}};
  assign pe_weight = pipe_vld_s ? wram_rdata : {DATA_W{1'b0}};

`ifdef PE_FEEDER_PERF_EN
  logic [31:0] row_cnt_q, inst_cnt_q;

  // Saturating delivered-row and completed-instruction counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_cnt_q  <= 32'd0;
      inst_cnt_q <= 32'd0;
    end else begin
      if (pipe_vld_s && (row_cnt_q != 32'hFFFF_FFFF)) begin
        row_cnt_q <= row_cnt_q + 32'd1;
      end else begin
        row_cnt_q <= row_cnt_q;
      end
      if (pipe_vld_s && pipe_ctl_s[CTL_LAST] && (inst_cnt_q != 32'hFFFF_FFFF)) begin
        inst_cnt_q <= inst_cnt_q + 32'd1;
      end else begin
        inst_cnt_q <= inst_cnt_q;
      end
    end
  end

  assign perf_row_cnt  = row_cnt_q;
  assign perf_inst_cnt = inst_cnt_q;
`else
  assign perf_row_cnt  = 32'd0;
  assign perf_inst_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pe_feeder.sv
// Randomized and directed bench for pe_feeder against a cycle-schedule reference model.
module tb_pe_feeder;

  localparam int DATA_W = 512;
  localparam int ADDR_W = 16;
  localparam int LEN_W  = 8;
  localparam int RD_LAT = 1;
  localparam int NCYC   = 4096;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              inst_vld;
  logic              inst_rdy;
  logic [LEN_W-1:0]  inst_len;
  logic [ADDR_W-1:0] inst_nbase, inst_wbase;
  logic              nram_rd_en, wram_rd_en;
  logic [ADDR_W-1:0] nram_addr, wram_addr;
  logic [DATA_W-1:0] nram_rdata, wram_rdata, pe_neuron, pe_weight;
  logic [1:0]        pe_ctl;
  logic              pe_vld, busy, err_zero_len;
  logic [31:0]       perf_row_cnt, perf_inst_cnt;

  int checks = 0;
  int errors = 0;

  pe_feeder #(
    .DATA_W (DATA_W), .ADDR_W (ADDR_W), .LEN_W (LEN_W), .RD_LAT (RD_LAT)
  ) dut (
    .clk (clk), .rst_n (rst_n),
    .inst_vld (inst_vld), .inst_rdy (inst_rdy), .inst_len (inst_len),
    .inst_nbase (inst_nbase), .inst_wbase (inst_wbase),
    .nram_rd_en (nram_rd_en), .nram_addr (nram_addr), .nram_rdata (nram_rdata),
    .wram_rd_en (wram_rd_en), .wram_addr (wram_addr), .wram_rdata (wram_rdata),
    .pe_neuron (pe_neuron), .pe_weight (pe_weight), .pe_ctl (pe_ctl),
    .pe_vld (pe_vld), .busy (busy), .err_zero_len (err_zero_len),
    .perf_row_cnt (perf_row_cnt), .perf_inst_cnt (perf_inst_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] nmem(input logic [15:0] a);
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W/32; i++) r[i*32 +: 32] = {a, a ^ 16'(i * 4099)};
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] wmem(input logic [15:0] a);
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W/32; i++) r[i*32 +: 32] = {~a, a + 16'(i)};
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] junk();
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W/32; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  // SRAM models: garbage on idle cycles so masking of invalid rows is exercised.
  logic [DATA_W-1:0] n_pipe [RD_LAT];
  logic [DATA_W-1:0] w_pipe [RD_LAT];
  always @(posedge clk) begin
    n_pipe[0] <= nram_rd_en ? nmem(nram_addr) : junk();
    w_pipe[0] <= wram_rd_en ? wmem(wram_addr) : junk();
    for (int i = 1; i < RD_LAT; i++) begin
      n_pipe[i] <= n_pipe[i-1];
      w_pipe[i] <= w_pipe[i-1];
    end
  end
  assign nram_rdata = n_pipe[RD_LAT-1];
  assign wram_rdata = w_pipe[RD_LAT-1];

  // Reference model: per-cycle schedule of expected issue and delivery.
  bit          exp_rd  [NCYC];
  bit          exp_pv  [NCYC];
  bit          exp_err [NCYC];
  logic [15:0] exp_na  [NCYC];
  logic [15:0] exp_wa  [NCYC];
  logic [15:0] exp_pna [NCYC];
  logic [15:0] exp_pwa [NCYC];
  logic [1:0]  exp_ctl [NCYC];
  int          cyc, issue_last, rows_m, insts_m;

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic init_model();
    for (int i = 0; i < NCYC; i++) begin
      exp_rd[i] = 1'b0; exp_pv[i] = 1'b0; exp_err[i] = 1'b0; exp_ctl[i] = 2'b00;
      exp_na[i] = 16'h0; exp_wa[i] = 16'h0; exp_pna[i] = 16'h0; exp_pwa[i] = 16'h0;
    end
    cyc = 8; issue_last = 0; rows_m = 0; insts_m = 0;
  endtask

  task automatic tick(output bit hs);
    int x, lenv;
    bit b;
    logic [15:0] nb, wb;
    x = cyc;
    chk("nram_rd_en", nram_rd_en, exp_rd[x]);
    chk("wram_rd_en", wram_rd_en, exp_rd[x]);
    if (exp_rd[x]) begin
      chk("nram_addr", nram_addr, exp_na[x]);
      chk("wram_addr", wram_addr, exp_wa[x]);
    end
    chk("inst_rdy", inst_rdy, x >= issue_last);
    chk("pe_vld", pe_vld, exp_pv[x]);
    chk("pe_ctl", pe_ctl, exp_pv[x] ? exp_ctl[x] : 2'b00);
    chk("pe_neuron", pe_neuron, exp_pv[x] ? nmem(exp_pna[x]) : {DATA_W{1'b0}});
    chk("pe_weight", pe_weight, exp_pv[x] ? wmem(exp_pwa[x]) : {DATA_W{1'b0}});
    b = exp_rd[x];
    for (int k = 1; k <= RD_LAT; k++) b |= exp_rd[x-k];
    chk("busy", busy, b);
    chk("err_zero_len", err_zero_len, exp_err[x]);
`ifdef PE_FEEDER_PERF_EN
    chk("perf_row_cnt", perf_row_cnt, rows_m);
    chk("perf_inst_cnt", perf_inst_cnt, insts_m);
`else
    chk("perf_row_cnt", perf_row_cnt, 32'd0);
    chk("perf_inst_cnt", perf_inst_cnt, 32'd0);
`endif
    hs = inst_vld && (x >= issue_last);
    lenv = int'(inst_len); nb = inst_nbase; wb = inst_wbase;
    @(posedge clk);
    cyc = x + 1;
    if (exp_pv[x]) rows_m++;
    if (exp_pv[x] && exp_ctl[x][1]) insts_m++;
    if (hs) begin
      if (lenv == 0) exp_err[cyc] = 1'b1;
      else begin
        for (int k = 0; k < lenv; k++) begin
          exp_rd[cyc+k]         = 1'b1;
          exp_na[cyc+k]         = nb + 16'(k);
          exp_wa[cyc+k]         = wb + 16'(k);
          exp_pv[cyc+RD_LAT+k]  = 1'b1;
          exp_ctl[cyc+RD_LAT+k] = {k == lenv-1, k == 0};
          exp_pna[cyc+RD_LAT+k] = nb + 16'(k);
          exp_pwa[cyc+RD_LAT+k] = wb + 16'(k);
        end
        issue_last = cyc + lenv - 1;
      end
    end
    @(negedge clk);
  endtask

  task automatic send(input int len, input logic [15:0] nb, input logic [15:0] wb);
    bit hs;
    int n;
    n = 0;
    inst_vld = 1'b1; inst_len = 8'(len); inst_nbase = nb; inst_wbase = wb;
    do begin
      tick(hs);
      n++;
    end while (!hs && n < 400);
    chk("accept_timeout", hs, 1'b1);
    inst_vld = 1'b0;
    inst_len = 8'($urandom()); inst_nbase = 16'($urandom()); inst_wbase = 16'($urandom());
  endtask

  task automatic idle(input int n);
    bit hs;
    inst_vld = 1'b0;
    for (int i = 0; i < n; i++) begin
      inst_len = 8'($urandom()); inst_nbase = 16'($urandom()); inst_wbase = 16'($urandom());
      tick(hs);
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_inst_rdy", inst_rdy, 1'b1);
    chk("rst_pe_vld", pe_vld, 1'b0);
    chk("rst_pe_ctl", pe_ctl, 2'b00);
    chk("rst_pe_neuron", pe_neuron, {DATA_W{1'b0}});
    chk("rst_pe_weight", pe_weight, {DATA_W{1'b0}});
    chk("rst_nram_rd_en", nram_rd_en, 1'b0);
    chk("rst_wram_rd_en", wram_rd_en, 1'b0);
    chk("rst_nram_addr", nram_addr, 16'h0);
    chk("rst_wram_addr", wram_addr, 16'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err_zero_len, 1'b0);
    chk("rst_perf_row", perf_row_cnt, 32'd0);
    chk("rst_perf_inst", perf_inst_cnt, 32'd0);
  endtask

  initial begin
    int len;
    bit hs;
    rst_n = 1'b0; inst_vld = 1'b0; inst_len = 8'd0; inst_nbase = 16'h0; inst_wbase = 16'h0;
    repeat (3) @(negedge clk);
    chk_reset_outputs();
    rst_n = 1'b1;
    init_model();
    idle(3);

    send(3, 16'h0000, 16'h0010);
    idle(5);
    send(2, 16'h0100, 16'h0200);
    send(1, 16'h0300, 16'h0400);
    idle(5);
    send(0, 16'h1234, 16'h5678);
    idle(4);
    send(2, 16'hFFFF, 16'h8000);
    idle(4);

    for (int i = 0; i < 60; i++) begin
      len = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 12));
      send(len, ($urandom_range(0, 3) == 0) ? 16'hFFFA : 16'($urandom()), 16'($urandom()));
      if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
    end
    idle(4);
    send(255, 16'hFF80, 16'h0001);
    send(1, 16'h0042, 16'h0043);
    idle(5);

    send(5, 16'h1000, 16'h2000);
    tick(hs);
    tick(hs);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    init_model();
    idle(6);

    send(3, 16'h0500, 16'h0600);
    send(2, 16'h0700, 16'h0800);
    send(1, 16'h0900, 16'h0A00);
    idle(6);
`ifdef PE_FEEDER_PERF_EN
    chk("perf_row_final", perf_row_cnt, 32'd6);
    chk("perf_inst_final", perf_inst_cnt, 32'd3);
`else
    chk("perf_row_final", perf_row_cnt, 32'd0);
    chk("perf_inst_final", perf_inst_cnt, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
